// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM encoding
// and the index-to-onehot helper used to build grant/ack vectors.
package shared_reg_arb_pkg;

    // Widest requester vector the helper supports (NUM_REQ is limited to 2..8).
    localparam int MAX_REQ = 8;

    // FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // One-hot vector with bit idx set; callers size-cast to their NUM_REQ.
    function automatic logic [MAX_REQ-1:0] onehot_from_idx(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found when searching upward (with wrap) from the slot after ptr.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan NUM_REQ slots starting just past ptr; the first hit wins, so the
    // slot held by ptr itself is examined last (lowest priority).
    always_comb begin
        any     = |req;
        winner  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared DATA_W-bit register.
// A request is granted at E0, the winner's data is written and acked at
// E1 (if the request is still held), and the block returns to IDLE at E2.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         reg_out,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [DATA_W-1:0]   r_reg;
    logic [IDX_W-1:0]    r_owner;
    logic                w_wr_en;
    logic                w_any;
    logic [IDX_W-1:0]    w_win;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_win)
    );

    // Next-state and next-output decode. In GRANT the winner is r_ptr,
    // because ptr was loaded with the winner on the IDLE->GRANT edge.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_wr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = NUM_REQ'(onehot_from_idx(3'(w_win)));
                    w_ptr_nxt   = w_win;
                end
            end
            GRANT: begin
                if (req[r_ptr]) begin
                    w_wr_en     = 1'b1;
                    w_gnt_nxt   = NUM_REQ'(onehot_from_idx(3'(r_ptr)));
                    w_ack_nxt   = NUM_REQ'(onehot_from_idx(3'(r_ptr)));
                    w_state_nxt = ACK;
                end else begin
                    // Withdrawn request: no write, ptr keeps the withdrawn
                    // index so that requester drops to lowest priority.
                    w_state_nxt = IDLE;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, registered grant/ack, and the shared register itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_ack   <= '0;
            r_reg   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            if (w_wr_en) begin
                r_reg   <= wdata[r_ptr*DATA_W +: DATA_W];
                r_owner <= r_ptr;
            end
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign reg_out = r_reg;
    assign owner   = r_owner;
    assign busy    = (r_state != IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter for one shared DATA_W-bit storage register. Up to NUM_REQ requesters post a write request with data. The block grants exactly one requester at a time, loads that requester's data into the register, and acknowledges it. It sits in front of the register datapath and gives the rest of the design a single, sequenced write port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, register/data width
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- req  in  NUM_REQ  per-requester write request, level
- wdata  in  NUM_REQ*DATA_W  packed write data; requester i owns bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot grant, registered
- ack  out  NUM_REQ  one-hot write-done pulse, one cycle
- reg_out  out  DATA_W  shared register contents
- owner  out  IDX_W  index of last successful writer
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, GRANT, ACK.
- Reset values:
  - state = IDLE
  - gnt = 0, ack = 0
  - reg_out = 0, owner = 0
  - busy = 0
  - internal ptr = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner w as the first set bit of req, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Next state is GRANT; gnt = onehot(w); ptr <= w.
- GRANT, req[w] high:
  - reg_out <= wdata slice w; owner <= w.
  - ack = onehot(w); gnt stays onehot(w).
  - Next state is ACK.
- GRANT, req[w] low (requester withdrew):
  - No write; reg_out and owner are unchanged; no ack.
  - gnt cleared; next state is IDLE.
  - ptr keeps w, so the withdrawn requester moves to lowest priority.
- ACK:
  - ack and gnt clear; next state is IDLE.
- Requester contract: deassert req in the cycle after ack is seen high. A req still high on the next IDLE edge is treated as a new request.
- Requests from non-winners during GRANT or ACK are ignored. They are re-evaluated in IDLE.
- gnt and ack are always one-hot or zero; they never name different requesters.
- reg_out changes only on the GRANT->ACK edge.

## Timing
- The edge sampling req in IDLE is E0. gnt is visible after E0.
- reg_out, owner, and ack are updated at E1.
- ack and gnt drop at E2. The FSM is in IDLE after E2.
- Request-to-data latency: 2 cycles. Sustained throughput: one write per 3 cycles.
- Fairness: with all NUM_REQ requesters continuously requesting, grant order is 0,1,…,NUM_REQ-1,0,…
- No requester waits more than NUM_REQ grants.
- reset wins over every state in the same cycle:
  - An in-flight GRANT is abandoned; no write, no ack.
  - reg_out returns to 0.
- Data only needs to be stable at E1 (the GRANT edge). wdata is not sampled at E0.

## Structure
- Package shared_reg_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, GRANT=2'd1, ACK=2'd2
  - the onehot-from-index helper function
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: any, winner index.
  - Parameterised by NUM_REQ. Reusable by other arbiters.
- The top level holds the FSM, ptr, the register, owner, and the output flops.

## Test plan
- Reset then idle: assert reset for 2 cycles -> reg_out=8'h00, gnt=0, ack=0, busy=0; no activity over 10 cycles with req=0.
- Single write: req[2]=1, wdata slice2=8'hA5, dropped after ack -> gnt=4'b0100 after E0, reg_out=8'hA5, owner=2, ack=4'b0100 after E1, idle after E2.
- Fairness: req=4'b1111 held, slices 8'h10/8'h20/8'h30/8'h40, each requester drops req for one cycle after its ack -> reg_out sequence 10,20,30,40,10; acks one-hot in order 0,1,2,3,0.
- Withdrawal: req[1] pulsed for one cycle only, with reg_out=8'h55 beforehand -> gnt=4'b0010 for one cycle, no ack, reg_out stays 8'h55; next grant goes to the following requester.
- Reset mid-operation: reset asserted in GRANT while req[3]=1, wdata slice3=8'hFF -> no ack, reg_out=8'h00, gnt=0; after release, req[3] still high -> requester 0 priority restored, so 3 wins only if 0-2 idle.
- Ignored contention: req[0] granted, req[1] raised during GRANT -> req[1] served only after the IDLE return; its gnt appears at E3 (two cycles after the ack edge E1), never overlapping ack[0].
